// File: rtl/gift_shop_pkg.sv
// Shared definitions for the day-2 range stream: ASCII codes, BCD field
// sizes, word layout and the packer FSM state encoding.
package gift_shop_pkg;

  localparam int DIGITS          = 10;
  localparam int BCD_W           = 4 * DIGITS;
  localparam int RANGE_W         = 2 * BCD_W;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_RANGE = 3;
  localparam int DIG_CNT_W       = $clog2(DIGITS + 1);

  // A range is {start, end}; word k is bits [32k+31:32k] of that 80-bit
  // value, zero-extended. So word0 = end[31:0],
  // word1 = {start[23:0], end[39:32]}, word2 = {16'h0, start[39:24]}.
  localparam int WORD0_LSB = 0;
  localparam int WORD1_LSB = WORD_W;
  localparam int WORD2_LSB = 2 * WORD_W;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_DASH  = 8'h2D;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [3:0] {
    S_START_DIG = 4'd0,
    S_START     = 4'd1,
    S_END_DIG   = 4'd2,
    S_END       = 4'd3,
    S_SEND0     = 4'd4,
    S_SEND1     = 4'd5,
    S_SEND2     = 4'd6,
    S_DONE      = 4'd7,
    S_ERROR     = 4'd8
  } state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  function automatic logic is_sep(input logic [7:0] c);
    return (c == CH_COMMA) || (c == CH_LF) || (c == CH_CR);
  endfunction

endpackage

// File: rtl/gift_shop_word_serializer.sv
// Splits one 80-bit {start,end} range into three 32-bit words, low word
// first, over a valid/ready link. A word moves when o_valid & i_ready are
// both high on a clock edge; o_valid and o_data hold until that happens.
module gift_shop_word_serializer
  import gift_shop_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [RANGE_W-1:0] i_range,
  input  logic               i_ready,
  output logic [WORD_W-1:0]  o_data,
  output logic               o_valid,
  output logic               o_xfer
);

  logic [RANGE_W-1:0] r_buf;
  logic [1:0]         r_idx;
  logic               r_valid;
  logic               w_xfer;

  assign w_xfer  = r_valid & i_ready;
  assign o_xfer  = w_xfer;
  assign o_valid = r_valid;
  assign o_data  = r_valid ? r_buf[WORD_W-1:0] : '0;

  // Load a whole range, then shift one word out per accepted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_buf   <= i_range;
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      r_buf <= {{WORD_W{1'b0}}, r_buf[RANGE_W-1:WORD_W]};
      if (r_idx == 2'(WORDS_PER_RANGE - 1)) begin
        r_idx   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gift_shop_range_packer.sv
// Parses ASCII "a-b,c-d,...\n" text byte by byte into packed-BCD ranges and
// forwards each range as three 32-bit words to the gift-shop solver.
// Byte side: a byte moves when byte_valid & byte_ready on a clock edge.
// Word side: a word moves when valid_out & ready_in on a clock edge.
module gift_shop_range_packer
  import gift_shop_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  input  logic               byte_last,
  output logic               byte_ready,
  output logic [WORD_W-1:0]  data_out,
  output logic               valid_out,
  input  logic               ready_in,
  output logic [COUNT_W-1:0] range_count,
  output logic               done,
  output logic               error,
  output logic [3:0]         dbg_state
);

  state_t               r_state, w_state_nxt;
  logic [BCD_W-1:0]     r_start, w_start_nxt;
  logic [BCD_W-1:0]     r_end, w_end_nxt;
  logic [DIG_CNT_W-1:0] r_digits, w_digits_nxt;
  logic                 r_last_seen, w_last_nxt;
  logic [COUNT_W-1:0]   r_count;
  logic                 w_load;
  logic                 w_count_inc;
  logic                 w_acc;
  logic                 w_ser_xfer;
  logic                 w_digit;
  logic                 w_sep;
  logic [BCD_W-1:0]     w_nib_ext;

  assign w_digit   = is_digit(byte_in);
  assign w_sep     = is_sep(byte_in);
  assign w_nib_ext = {{(BCD_W-4){1'b0}}, byte_in[3:0]};
  assign w_acc     = byte_valid & byte_ready;

  // Bytes are taken while parsing or draining after an error; never during
  // a send, after done, or while reset is held.
  assign byte_ready = !rst && ((r_state == S_START_DIG) || (r_state == S_START) ||
                               (r_state == S_END_DIG) || (r_state == S_END) ||
                               (r_state == S_ERROR));

  assign done        = (r_state == S_DONE);
  assign error       = (r_state == S_ERROR);
  assign range_count = r_count;
  assign dbg_state   = r_state;

  // State and field registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_START_DIG;
      r_start     <= '0;
      r_end       <= '0;
      r_digits    <= '0;
      r_last_seen <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_start     <= w_start_nxt;
      r_end       <= w_end_nxt;
      r_digits    <= w_digits_nxt;
      r_last_seen <= w_last_nxt;
      if (w_count_inc) r_count <= r_count + 1'b1;
    end
  end

  // Parser next-state: digit accumulation, separators, byte_last and
  // launching the serializer with the just-completed range.
  always_comb begin
    w_state_nxt  = r_state;
    w_start_nxt  = r_start;
    w_end_nxt    = r_end;
    w_digits_nxt = r_digits;
    w_last_nxt   = r_last_seen;
    w_load       = 1'b0;
    w_count_inc  = 1'b0;
    case (r_state)
      S_START_DIG: if (w_acc) begin
        if (w_digit) begin
          w_start_nxt  = w_nib_ext;
          w_digits_nxt = DIG_CNT_W'(1);
          // A range cannot end on its first start digit.
          w_state_nxt  = byte_last ? S_ERROR : S_START;
        end else if (w_sep) begin
          if (byte_last) w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ERROR;
        end
      end
      S_START: if (w_acc) begin
        if (w_digit) begin
          if (r_digits == DIG_CNT_W'(DIGITS)) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_start_nxt  = {r_start[BCD_W-5:0], byte_in[3:0]};
            w_digits_nxt = r_digits + 1'b1;
            if (byte_last) w_state_nxt = S_ERROR;
          end
        end else if (byte_in == CH_DASH) begin
          w_state_nxt = byte_last ? S_ERROR : S_END_DIG;
        end else begin
          w_state_nxt = S_ERROR;
        end
      end
      S_END_DIG: if (w_acc) begin
        if (w_digit) begin
          w_end_nxt    = w_nib_ext;
          w_digits_nxt = DIG_CNT_W'(1);
          if (byte_last) begin
            w_load      = 1'b1;
            w_last_nxt  = 1'b1;
            w_state_nxt = S_SEND0;
          end else begin
            w_state_nxt = S_END;
          end
        end else begin
          w_state_nxt = S_ERROR;
        end
      end
      S_END: if (w_acc) begin
        if (w_digit) begin
          if (r_digits == DIG_CNT_W'(DIGITS)) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_end_nxt    = {r_end[BCD_W-5:0], byte_in[3:0]};
            w_digits_nxt = r_digits + 1'b1;
            if (byte_last) begin
              w_load      = 1'b1;
              w_last_nxt  = 1'b1;
              w_state_nxt = S_SEND0;
            end
          end
        end else if (w_sep) begin
          w_load      = 1'b1;
          w_last_nxt  = byte_last;
          w_state_nxt = S_SEND0;
        end else begin
          w_state_nxt = S_ERROR;
        end
      end
      S_SEND0: if (w_ser_xfer) w_state_nxt = S_SEND1;
      S_SEND1: if (w_ser_xfer) w_state_nxt = S_SEND2;
      S_SEND2: if (w_ser_xfer) begin
        w_count_inc = 1'b1;
        w_state_nxt = r_last_seen ? S_DONE : S_START_DIG;
      end
      S_DONE:  w_state_nxt = S_DONE;
      S_ERROR: w_state_nxt = S_ERROR;
      default: w_state_nxt = S_ERROR;
    endcase
  end

  gift_shop_word_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_range ({w_start_nxt, w_end_nxt}),
    .i_ready (ready_in),
    .o_data  (data_out),
    .o_valid (valid_out),
    .o_xfer  (w_ser_xfer)
  );

endmodule

// File: tb/tb_gift_shop_range_packer.sv
// Directed bench for gift_shop_range_packer: ASCII range text in, 32-bit
// packed BCD words out, with hand-computed expected words.
module tb_gift_shop_range_packer;
  import gift_shop_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic [31:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic [15:0] range_count;
  logic        done;
  logic        error;
  logic [3:0]  dbg_state;

  always #5 clk = ~clk;

  gift_shop_range_packer #(.COUNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_last   (byte_last),
    .byte_ready  (byte_ready),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .range_count (range_count),
    .done        (done),
    .error       (error),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  bit          saw_valid;

  // Collect every word that will transfer at the coming rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0 && valid_out === 1'b1) begin
      saw_valid = 1'b1;
      if (ready_in === 1'b1) got_q.push_back(data_out);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; byte_valid = 1'b0; byte_last = 1'b0; byte_in = 8'h00; ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    saw_valid = 1'b0;
  endtask

  // Presents one byte and returns 1ns after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    byte_in = b; byte_valid = 1'b1; byte_last = last;
    @(negedge clk);
    while (byte_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) begin
      $display("FAIL byte_accept_timeout byte=%h byte_ready=%b required=1", b, byte_ready);
      n_err++;
    end
    n_vec++;
    @(posedge clk);
    #1;
    byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_at_end);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], last_at_end && (i == s.len() - 1));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; byte_valid = 1'b0; byte_last = 1'b0; byte_in = 8'h00; ready_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (byte_ready !== 1'b0) begin $display("FAIL rst_byte_ready_low got=%b exp=0", byte_ready); n_err++; end n_vec++;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    if (byte_ready !== 1'b1) begin $display("FAIL rst_byte_ready_high got=%b exp=1", byte_ready); n_err++; end n_vec++;
    if (valid_out !== 1'b0) begin $display("FAIL rst_valid_out got=%b exp=0", valid_out); n_err++; end n_vec++;
    if (data_out !== 32'h0) begin $display("FAIL rst_data_out got=%h exp=00000000", data_out); n_err++; end n_vec++;
    if (range_count !== 16'd0) begin $display("FAIL rst_range_count got=%0d exp=0", range_count); n_err++; end n_vec++;
    if (done !== 1'b0) begin $display("FAIL rst_done got=%b exp=0", done); n_err++; end n_vec++;
    if (error !== 1'b0) begin $display("FAIL rst_error got=%b exp=0", error); n_err++; end n_vec++;
    if (dbg_state !== S_START_DIG) begin $display("FAIL rst_state got=%0d exp=%0d", dbg_state, S_START_DIG); n_err++; end n_vec++;
  endtask

  task automatic test_single_range();
    do_reset();
    exp_q = '{32'h00000022, 32'h00001100, 32'h00000000};
    send_str("11-22\n", 1'b1);
    wait_done();
    if (got_q.size() != exp_q.size()) begin $display("FAIL single_word_count got=%0d exp=%0d", got_q.size(), exp_q.size()); n_err++; end n_vec++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin $display("FAIL single_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); n_err++; end
      n_vec++;
    end
    if (range_count !== 16'd1) begin $display("FAIL single_range_count got=%0d exp=1", range_count); n_err++; end n_vec++;
    if (done !== 1'b1) begin $display("FAIL single_done got=%b exp=1", done); n_err++; end n_vec++;
    if (error !== 1'b0) begin $display("FAIL single_error got=%b exp=0", error); n_err++; end n_vec++;
  endtask

  task automatic test_latency();
    do_reset();
    send_str("11-22,", 1'b0);
    // now in the cycle after the terminating comma was accepted
    @(negedge clk);
    if (valid_out !== 1'b1) begin $display("FAIL lat_n1_valid got=%b exp=1", valid_out); n_err++; end n_vec++;
    if (data_out !== 32'h00000022) begin $display("FAIL lat_n1_word0 got=%h exp=00000022", data_out); n_err++; end n_vec++;
    if (byte_ready !== 1'b0) begin $display("FAIL lat_n1_byte_ready got=%b exp=0", byte_ready); n_err++; end n_vec++;
    @(negedge clk);
    if (data_out !== 32'h00001100) begin $display("FAIL lat_n2_word1 got=%h exp=00001100", data_out); n_err++; end n_vec++;
    if (byte_ready !== 1'b0) begin $display("FAIL lat_n2_byte_ready got=%b exp=0", byte_ready); n_err++; end n_vec++;
    @(negedge clk);
    if (valid_out !== 1'b1) begin $display("FAIL lat_n3_valid got=%b exp=1", valid_out); n_err++; end n_vec++;
    if (byte_ready !== 1'b0) begin $display("FAIL lat_n3_byte_ready got=%b exp=0", byte_ready); n_err++; end n_vec++;
    @(negedge clk);
    if (byte_ready !== 1'b1) begin $display("FAIL lat_n4_byte_ready got=%b exp=1", byte_ready); n_err++; end n_vec++;
    if (valid_out !== 1'b0) begin $display("FAIL lat_n4_valid got=%b exp=0", valid_out); n_err++; end n_vec++;
    if (range_count !== 16'd1) begin $display("FAIL lat_n4_count got=%0d exp=1", range_count); n_err++; end n_vec++;
    // trailing separator with byte_last: finish without another send
    @(posedge clk); #1;
    send_byte(CH_LF, 1'b1);
    wait_done();
    if (done !== 1'b1) begin $display("FAIL lat_sep_last_done got=%b exp=1", done); n_err++; end n_vec++;
    if (got_q.size() != 3) begin $display("FAIL lat_word_count got=%0d exp=3", got_q.size()); n_err++; end n_vec++;
    if (range_count !== 16'd1) begin $display("FAIL lat_final_count got=%0d exp=1", range_count); n_err++; end n_vec++;
  endtask

  task automatic test_two_ranges();
    do_reset();
    exp_q = '{32'h00001012, 32'h00099800, 32'h00000000,
              32'h88511890, 32'h51188011, 32'h00001188};
    send_str("998-1012,1188511880-1188511890", 1'b1);
    wait_done();
    if (got_q.size() != exp_q.size()) begin $display("FAIL two_word_count got=%0d exp=%0d", got_q.size(), exp_q.size()); n_err++; end n_vec++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin $display("FAIL two_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); n_err++; end
      n_vec++;
    end
    if (range_count !== 16'd2) begin $display("FAIL two_range_count got=%0d exp=2", range_count); n_err++; end n_vec++;
    if (done !== 1'b1) begin $display("FAIL two_done got=%b exp=1", done); n_err++; end n_vec++;
  endtask

  task automatic test_backpressure();
    logic [0:3]  pat;
    logic        prev_stall;
    logic [31:0] prev_data;
    pat = 4'b1001;
    prev_stall = 1'b0;
    prev_data = 32'h0;
    do_reset();
    exp_q = '{32'h00000022, 32'h00001100, 32'h00000000};
    send_str("11-22\n", 1'b1);
    for (int k = 0; k < 40; k++) begin
      ready_in = pat[k % 4];
      @(negedge clk);
      if (valid_out === 1'b1) begin
        if (byte_ready !== 1'b0) begin $display("FAIL bp_byte_ready k=%0d got=%b exp=0", k, byte_ready); n_err++; end
        n_vec++;
      end
      if (prev_stall) begin
        if (valid_out !== 1'b1) begin $display("FAIL bp_valid_held k=%0d got=%b exp=1", k, valid_out); n_err++; end n_vec++;
        if (data_out !== prev_data) begin $display("FAIL bp_data_held k=%0d got=%h exp=%h", k, data_out, prev_data); n_err++; end n_vec++;
      end
      prev_stall = valid_out && !ready_in;
      prev_data  = data_out;
      if (got_q.size() >= 3) break;
      @(posedge clk); #1;
    end
    ready_in = 1'b1;
    wait_done();
    if (got_q.size() != exp_q.size()) begin $display("FAIL bp_word_count got=%0d exp=%0d", got_q.size(), exp_q.size()); n_err++; end n_vec++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin $display("FAIL bp_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); n_err++; end
      n_vec++;
    end
    if (range_count !== 16'd1) begin $display("FAIL bp_range_count got=%0d exp=1", range_count); n_err++; end n_vec++;
  endtask

  task automatic test_bad_char();
    do_reset();
    send_str("12", 1'b0);
    @(negedge clk);
    if (error !== 1'b0) begin $display("FAIL bad_pre_error got=%b exp=0", error); n_err++; end n_vec++;
    send_byte("a", 1'b0);
    @(negedge clk);
    if (error !== 1'b1) begin $display("FAIL bad_error_on_a got=%b exp=1", error); n_err++; end n_vec++;
    send_str("-3", 1'b0);
    @(negedge clk);
    if (byte_ready !== 1'b1) begin $display("FAIL bad_byte_ready got=%b exp=1", byte_ready); n_err++; end n_vec++;
    if (done !== 1'b0) begin $display("FAIL bad_done got=%b exp=0", done); n_err++; end n_vec++;
    if (error !== 1'b1) begin $display("FAIL bad_error_sticky got=%b exp=1", error); n_err++; end n_vec++;
    if (saw_valid !== 1'b0) begin $display("FAIL bad_no_valid got=%b exp=0", saw_valid); n_err++; end n_vec++;
  endtask

  task automatic test_digit_limit();
    do_reset();
    send_str("1234567890", 1'b0);
    @(negedge clk);
    if (error !== 1'b0) begin $display("FAIL lim_10_digits_error got=%b exp=0", error); n_err++; end n_vec++;
    send_byte("1", 1'b0);
    @(negedge clk);
    if (error !== 1'b1) begin $display("FAIL lim_11th_digit_error got=%b exp=1", error); n_err++; end n_vec++;
    send_str("-5", 1'b0);
    @(negedge clk);
    if (saw_valid !== 1'b0) begin $display("FAIL lim_no_valid got=%b exp=0", saw_valid); n_err++; end n_vec++;

    do_reset();
    exp_q = '{32'h99999999, 32'h99999999, 32'h00009999};
    send_str("9999999999-9999999999\n", 1'b1);
    wait_done();
    if (got_q.size() != exp_q.size()) begin $display("FAIL lim_word_count got=%0d exp=%0d", got_q.size(), exp_q.size()); n_err++; end n_vec++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin $display("FAIL lim_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); n_err++; end
      n_vec++;
    end
    if (error !== 1'b0) begin $display("FAIL lim_10x10_error got=%b exp=0", error); n_err++; end n_vec++;
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    send_str("11-22\n", 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    if (dbg_state !== S_SEND1) begin $display("FAIL mid_in_send1 got=%0d exp=%0d", dbg_state, S_SEND1); n_err++; end n_vec++;
    if (data_out !== 32'h00001100) begin $display("FAIL mid_word1 got=%h exp=00001100", data_out); n_err++; end n_vec++;
    #1;
    ready_in = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ready_in = 1'b1;
    @(negedge clk);
    if (valid_out !== 1'b0) begin $display("FAIL mid_valid_cleared got=%b exp=0", valid_out); n_err++; end n_vec++;
    if (data_out !== 32'h0) begin $display("FAIL mid_data_cleared got=%h exp=00000000", data_out); n_err++; end n_vec++;
    if (range_count !== 16'd0) begin $display("FAIL mid_count got=%0d exp=0", range_count); n_err++; end n_vec++;
    if (done !== 1'b0) begin $display("FAIL mid_done got=%b exp=0", done); n_err++; end n_vec++;

    // re-feed the first case and expect identical output
    @(posedge clk); #1;
    got_q.delete();
    exp_q = '{32'h00000022, 32'h00001100, 32'h00000000};
    send_str("11-22\n", 1'b1);
    wait_done();
    if (got_q.size() != exp_q.size()) begin $display("FAIL refeed_word_count got=%0d exp=%0d", got_q.size(), exp_q.size()); n_err++; end n_vec++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin $display("FAIL refeed_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); n_err++; end
      n_vec++;
    end
    if (range_count !== 16'd1) begin $display("FAIL refeed_count got=%0d exp=1", range_count); n_err++; end n_vec++;
    if (done !== 1'b1) begin $display("FAIL refeed_done got=%b exp=1", done); n_err++; end n_vec++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    saw_valid = 1'b0;
    test_reset();
    test_single_range();
    test_latency();
    test_two_ranges();
    test_backpressure();
    test_bad_char();
    test_digit_limit();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
